pipe_fwd_hazard_unit: RTL and testbench

- Parametrised decode-stage forwarding and interlock unit for the 5+-stage MIPS pipeline.
- Keeps its own shift pipeline of in-flight destination records, so the ID stage no longer needs per-stage ewreg/mwreg/ern/mrn wiring.
- Supports N forwarding stages, a configurable load-data stage, and a multi-cycle multiplier with scoreboard interlock.
- Sits in the ID stage between the register file and the ID/EXE pipeline register. It outputs the forwarded operands plus the pipeline-advance and bubble controls.

---
 rtl/pipe_fwd_hazard_unit_pkg.sv | 15 +
 rtl/pipe_fwd_hazard_unit_fwd_sel_logic.sv | 54 +++++
 rtl/pipe_fwd_hazard_unit.sv | 154 +++++++++++++++
 tb/tb_pipe_fwd_hazard_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_fwd_hazard_unit_pkg.sv
// Shared operand-select encodings for the decode-stage forwarding unit.
package pipe_fwd_hazard_unit_pkg;

   // Operand source encodings; stage k of the in-flight pipeline uses FWD_SEL_STAGE0 + k.
   localparam int FWD_SEL_RF     = 0;
   localparam int FWD_SEL_MMO    = 1;
   localparam int FWD_SEL_MUL    = 2;
   localparam int FWD_SEL_STAGE0 = 3;

   // Select code for forwarding from post-ID stage k.
   function automatic int stage_sel(input int k);
      return FWD_SEL_STAGE0 + k;
   endfunction

endpackage

// File: rtl/pipe_fwd_hazard_unit_fwd_sel_logic.sv
// Per-operand priority scan: mul scoreboard first, then youngest matching stage.
module fwd_sel_logic
   import pipe_fwd_hazard_unit_pkg::*;
#(
   parameter int NFWD         = 3,
   parameter int REG_ADDR_LEN = 5,
   parameter int LOAD_STAGE   = 1,
   parameter int SEL_W        = 3
) (
   input  logic                         use_src,
   input  logic [REG_ADDR_LEN-1:0]      src,
   input  logic [NFWD-1:0]              rec_valid,
   input  logic [NFWD-1:0]              rec_wreg,
   input  logic [NFWD-1:0]              rec_m2reg,
   input  logic [NFWD*REG_ADDR_LEN-1:0] rec_rn,
   input  logic                         mul_pend,
   input  logic [REG_ADDR_LEN-1:0]      mul_rn,
   input  logic                         mul_done,
   output logic [SEL_W-1:0]             sel,
   output logic                         stall
);

   logic [NFWD-1:0] hit;
   logic            found;

   // A stage hits when it will write the source register; $0 is filtered below.
   for (genvar gi = 0; gi < NFWD; gi++) begin : g_hit
      assign hit[gi] = rec_valid[gi] & rec_wreg[gi] &
                       (rec_rn[gi*REG_ADDR_LEN +: REG_ADDR_LEN] == src);
   end

   // Priority resolution: pending mul wins, otherwise the lowest (youngest) hitting stage.
   always_comb begin
      sel   = SEL_W'(FWD_SEL_RF);
      stall = 1'b0;
      found = 1'b0;
      if (use_src && (src != '0)) begin
         if (mul_pend && (mul_rn == src)) begin
            found = 1'b1;
            if (mul_done) sel = SEL_W'(FWD_SEL_MUL);
            else          stall = 1'b1;
         end
         for (int k = 0; k < NFWD; k++) begin
            if (!found && hit[k]) begin
               found = 1'b1;
               if (rec_m2reg[k] && (k < LOAD_STAGE))       stall = 1'b1;
               else if (rec_m2reg[k] && (k == LOAD_STAGE)) sel = SEL_W'(FWD_SEL_MMO);
               else                                        sel = SEL_W'(stage_sel(k));
            end
         end
      end
   end

endmodule

// File: rtl/pipe_fwd_hazard_unit.sv
// Decode-stage forwarding and interlock unit with its own in-flight destination
// pipeline and a scoreboard for the multi-cycle multiplier.
module pipe_fwd_hazard_unit
   import pipe_fwd_hazard_unit_pkg::*;
#(
   parameter int DATA_LEN     = 32,
   parameter int REG_ADDR_LEN = 5,
   parameter int NFWD         = 3,
   parameter int LOAD_STAGE   = 1,
   parameter int MUL_LAT      = 4,
   parameter int SEL_W        = $clog2(NFWD+3)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     id_valid,
   input  logic [REG_ADDR_LEN-1:0]  id_rs,
   input  logic [REG_ADDR_LEN-1:0]  id_rt,
   input  logic                     id_use_rs,
   input  logic                     id_use_rt,
   input  logic                     id_wreg,
   input  logic                     id_m2reg,
   input  logic                     id_mul,
   input  logic [REG_ADDR_LEN-1:0]  id_rn,
   input  logic                     flush,
   input  logic [DATA_LEN-1:0]      qa,
   input  logic [DATA_LEN-1:0]      qb,
   input  logic [NFWD*DATA_LEN-1:0] fwd_data,
   input  logic [DATA_LEN-1:0]      mmo,
   input  logic [DATA_LEN-1:0]      mul_result,
   output logic [DATA_LEN-1:0]      da,
   output logic [DATA_LEN-1:0]      db,
   output logic [SEL_W-1:0]         fwda,
   output logic [SEL_W-1:0]         fwdb,
   output logic                     wpcir,
   output logic                     bubble
);

   // Counter only needs to hold MUL_LAT-1.
   localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

   logic [NFWD-1:0]              rec_valid_reg, rec_valid_next;
   logic [NFWD-1:0]              rec_wreg_reg,  rec_wreg_next;
   logic [NFWD-1:0]              rec_m2reg_reg, rec_m2reg_next;
   logic [NFWD*REG_ADDR_LEN-1:0] rec_rn_reg,    rec_rn_next;

   logic                    mul_pend_reg;
   logic [REG_ADDR_LEN-1:0] mul_rn_reg;
   logic [CNT_W-1:0]        mul_cnt_reg;

   logic mul_done, mul_busy;
   logic stall_a, stall_b, stall_struct, stall_waw;
   logic live, advance;

   logic [DATA_LEN-1:0] cand [1:NFWD+2];

   assign mul_done = (mul_cnt_reg == '0);
   assign mul_busy = mul_pend_reg & (mul_cnt_reg != '0);

   fwd_sel_logic #(
      .NFWD(NFWD), .REG_ADDR_LEN(REG_ADDR_LEN), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
   ) u_sel_rs (
      .use_src(id_use_rs), .src(id_rs),
      .rec_valid(rec_valid_reg), .rec_wreg(rec_wreg_reg),
      .rec_m2reg(rec_m2reg_reg), .rec_rn(rec_rn_reg),
      .mul_pend(mul_pend_reg), .mul_rn(mul_rn_reg), .mul_done(mul_done),
      .sel(fwda), .stall(stall_a)
   );

   fwd_sel_logic #(
      .NFWD(NFWD), .REG_ADDR_LEN(REG_ADDR_LEN), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
   ) u_sel_rt (
      .use_src(id_use_rt), .src(id_rt),
      .rec_valid(rec_valid_reg), .rec_wreg(rec_wreg_reg),
      .rec_m2reg(rec_m2reg_reg), .rec_rn(rec_rn_reg),
      .mul_pend(mul_pend_reg), .mul_rn(mul_rn_reg), .mul_done(mul_done),
      .sel(fwdb), .stall(stall_b)
   );

   // A second mul cannot enter while one is still counting, and no younger
   // write may target the pending mul's destination before it lands.
   assign stall_struct = id_mul & mul_busy;
   assign stall_waw    = id_wreg & mul_busy & (id_rn == mul_rn_reg);

   // Flush kills the ID instruction, so it also cancels any stall it would cause.
   assign live    = id_valid & ~flush;
   assign wpcir   = ~(live & (stall_a | stall_b | stall_struct | stall_waw));
   assign bubble  = ~wpcir | flush;
   assign advance = live & wpcir;

   // Stage 0 takes the advancing ID instruction; later stages shift regardless of stalls.
   for (genvar gi = 0; gi < NFWD; gi++) begin : g_rec
      if (gi == 0) begin : g_head
         assign rec_valid_next[0]              = advance;
         assign rec_wreg_next[0]               = id_wreg & ~id_mul;
         assign rec_m2reg_next[0]              = id_m2reg;
         assign rec_rn_next[0 +: REG_ADDR_LEN] = id_rn;
      end else begin : g_shift
         assign rec_valid_next[gi] = rec_valid_reg[gi-1];
         assign rec_wreg_next[gi]  = rec_wreg_reg[gi-1];
         assign rec_m2reg_next[gi] = rec_m2reg_reg[gi-1];
         assign rec_rn_next[gi*REG_ADDR_LEN +: REG_ADDR_LEN] =
            rec_rn_reg[(gi-1)*REG_ADDR_LEN +: REG_ADDR_LEN];
      end
   end

   // In-flight destination record pipeline.
   always_ff @(posedge clock) begin
      if (reset) begin
         rec_valid_reg <= '0;
         rec_wreg_reg  <= '0;
         rec_m2reg_reg <= '0;
         rec_rn_reg    <= '0;
      end else begin
         rec_valid_reg <= rec_valid_next;
         rec_wreg_reg  <= rec_wreg_next;
         rec_m2reg_reg <= rec_m2reg_next;
         rec_rn_reg    <= rec_rn_next;
      end
   end

   // Mul scoreboard: arm on issue, count down, release the cycle after done.
   always_ff @(posedge clock) begin
      if (reset) begin
         mul_pend_reg <= 1'b0;
         mul_rn_reg   <= '0;
         mul_cnt_reg  <= '0;
      end else if (advance && id_mul) begin
         mul_pend_reg <= 1'b1;
         mul_rn_reg   <= id_rn;
         mul_cnt_reg  <= CNT_W'(MUL_LAT - 1);
      end else if (mul_pend_reg) begin
         if (mul_done) mul_pend_reg <= 1'b0;
         else          mul_cnt_reg  <= mul_cnt_reg - 1'b1;
      end
   end

   // Candidate sources shared by both operand muxes (index 0 is each operand's regfile port).
   assign cand[FWD_SEL_MMO] = mmo;
   assign cand[FWD_SEL_MUL] = mul_result;
   for (genvar gi = 0; gi < NFWD; gi++) begin : g_cand
      assign cand[FWD_SEL_STAGE0+gi] = fwd_data[gi*DATA_LEN +: DATA_LEN];
   end

   // NFWD+3 input operand muxes driven by the resolved selects.
   always_comb begin
      da = qa;
      db = qb;
      for (int k = 1; k < NFWD + 3; k++) begin
         if (fwda == SEL_W'(k)) da = cand[k];
         if (fwdb == SEL_W'(k)) db = cand[k];
      end
   end

endmodule

// File: tb/tb_pipe_fwd_hazard_unit.sv
// Directed bench for pipe_fwd_hazard_unit: one instruction per cycle through ID,
// combinational outputs checked mid-cycle against hand-computed values.
module tb_pipe_fwd_hazard_unit;

   localparam int DL = 32;
   localparam int RL = 5;
   localparam int NF = 3;
   localparam int SW = $clog2(NF+3);

   logic          clock;
   logic          reset;
   logic          id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_mul, flush;
   logic [RL-1:0] id_rs, id_rt, id_rn;
   logic [DL-1:0] qa, qb, mmo, mul_result;
   logic [NF*DL-1:0] fwd_data;
   logic [DL-1:0] da, db;
   logic [SW-1:0] fwda, fwdb;
   logic          wpcir, bubble;

   int n_asserts = 0;
   int n_fail    = 0;

   pipe_fwd_hazard_unit #(
      .DATA_LEN(DL), .REG_ADDR_LEN(RL), .NFWD(NF), .LOAD_STAGE(1), .MUL_LAT(4)
   ) dut (
      .clock(clock), .reset(reset), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_mul(id_mul), .id_rn(id_rn),
      .flush(flush), .qa(qa), .qb(qb), .fwd_data(fwd_data), .mmo(mmo),
      .mul_result(mul_result), .da(da), .db(db), .fwda(fwda), .fwdb(fwdb),
      .wpcir(wpcir), .bubble(bubble)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ctl(input string tag, input logic w, input logic b);
      chk({tag, ".wpcir"}, 32'(wpcir), 32'(w));
      chk({tag, ".bubble"}, 32'(bubble), 32'(b));
   endtask

   task automatic opa(input string tag, input int sel, input logic [31:0] d);
      chk({tag, ".fwda"}, 32'(fwda), 32'(sel));
      chk({tag, ".da"}, da, d);
   endtask

   task automatic opb(input string tag, input int sel, input logic [31:0] d);
      chk({tag, ".fwdb"}, 32'(fwdb), 32'(sel));
      chk({tag, ".db"}, db, d);
   endtask

   // Present one ID-stage instruction at the falling edge, then let outputs settle.
   task automatic step(input logic rst, input logic v, input logic fl,
                       input int rs, input int rt, input logic urs, input logic urt,
                       input logic wr, input logic ld, input logic ml, input int rn);
      @(negedge clock);
      reset     = rst;
      id_valid  = v;
      flush     = fl;
      id_rs     = RL'(rs);
      id_rt     = RL'(rt);
      id_use_rs = urs;
      id_use_rt = urt;
      id_wreg   = wr;
      id_m2reg  = ld;
      id_mul    = ml;
      id_rn     = RL'(rn);
      #2;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; id_valid = 1'b0; flush = 1'b0;
      id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      id_wreg = 1'b0; id_m2reg = 1'b0; id_mul = 1'b0; id_rn = '0;
      qa = 32'h111; qb = 32'h222; mmo = 32'hCAFE; mul_result = 32'h1234;
      fwd_data = {32'hB, 32'h77, 32'h11};

      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // add $3 <- $1,$2 right after reset
      step(0, 1, 0, 1, 2, 1, 1, 1, 0, 0, 3);
      ctl("reset_state", 1, 0); opa("reset_state", 0, 32'h111); opb("reset_state", 0, 32'h222);
      // add $4 <- $3,$3 back-to-back
      step(0, 1, 0, 3, 3, 1, 1, 1, 0, 0, 4);
      ctl("alu_fwd", 1, 0); opa("alu_fwd", 3, 32'h11); opb("alu_fwd", 3, 32'h11);
      // lw $5, 0($0)
      step(0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 5);
      ctl("lw_issue", 1, 0); opa("lw_issue", 0, 32'h111);
      // add $6 <- $5,$0 : load-use stall then mmo forward
      step(0, 1, 0, 5, 0, 1, 1, 1, 0, 0, 6);
      ctl("load_use_stall", 0, 1);
      step(0, 1, 0, 5, 0, 1, 1, 1, 0, 0, 6);
      ctl("load_mmo", 1, 0); opa("load_mmo", 1, 32'hCAFE); opb("load_mmo", 0, 32'h222);

      fwd_data = {32'hB, 32'h77, 32'hA};
      // add $3 <- $5,$6 : lw now in stage 2, add $6 in stage 0
      step(0, 1, 0, 5, 6, 1, 1, 1, 0, 0, 3);
      ctl("late_load", 1, 0); opa("late_load", 5, 32'hB); opb("late_load", 3, 32'hA);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      ctl("idle", 1, 0);
      // add $3 <- $1,$2 again so $3 sits in stages 0 and 2
      step(0, 1, 0, 1, 2, 1, 1, 1, 0, 0, 3);
      opa("no_match", 0, 32'h111);
      step(0, 1, 0, 3, 3, 1, 0, 1, 0, 0, 15);
      ctl("youngest", 1, 0); opa("youngest", 3, 32'hA); opb("unused_rt", 0, 32'h222);
      // add $0 <- $1,$2 then add $9 <- $0,$0
      step(0, 1, 0, 1, 2, 1, 1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 9);
      opa("reg_zero", 0, 32'h111); opb("reg_zero", 0, 32'h222);

      // mul $7 then add $8 <- $7,$0
      step(0, 1, 0, 1, 2, 1, 1, 1, 0, 1, 7);
      ctl("mul_issue", 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 7, 0, 1, 1, 1, 0, 0, 8);
         ctl($sformatf("mul_wait%0d", i), 0, 1);
      end
      step(0, 1, 0, 7, 0, 1, 1, 1, 0, 0, 8);
      ctl("mul_done", 1, 0); opa("mul_done", 2, 32'h1234);
      step(0, 1, 0, 7, 0, 1, 1, 1, 0, 0, 10);
      ctl("mul_cleared", 1, 0); opa("mul_cleared", 0, 32'h111);

      // mul $11, then a second mul (structural), then add $11 (WAW)
      step(0, 1, 0, 1, 2, 1, 1, 1, 0, 1, 11);
      ctl("mul2_issue", 1, 0);
      step(0, 1, 0, 1, 2, 1, 1, 1, 0, 1, 12);
      ctl("mul_struct", 0, 1);
      step(0, 1, 0, 1, 2, 1, 1, 1, 0, 0, 11);
      ctl("mul_waw", 0, 1);

      // reset while the mul is still counting
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 11, 2, 1, 1, 1, 0, 0, 12);
      ctl("reset_mid_mul", 1, 0); opa("reset_mid_mul", 0, 32'h111);

      // lw $5 then dependent add flushed in the same cycle
      step(0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 5);
      ctl("lw2_issue", 1, 0);
      step(0, 1, 1, 5, 0, 1, 1, 1, 0, 0, 6);
      ctl("flush_over_stall", 1, 1);
      // flushed mul $13 must not arm the scoreboard
      step(0, 1, 1, 1, 2, 1, 1, 1, 0, 1, 13);
      ctl("flush_mul", 1, 1);
      step(0, 1, 0, 13, 0, 1, 1, 1, 0, 0, 14);
      ctl("after_flush_mul", 1, 0); opa("after_flush_mul", 0, 32'h111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
